// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one external async SRAM between two requesters
// (port 0 = UART-RX enqueue, port 1 = UART-TX dequeue) with round-robin
// arbitration. Each grant runs one fixed SETUP / STROBE / HOLD cycle.
//
// Handshake: a requester raises reqN with weN/adrN/wdatN/beN stable and keeps
// them stable until it sees ackN. ackN is a one-cycle pulse during SETUP that
// means "fields latched"; the requester may then drop or re-raise reqN with
// new fields. Requests are only sampled in IDLE. For reads, rvalidN pulses for
// one cycle (HOLD) and qualifies the shared rdata bus, which holds its value
// until the next read completes.
module sram_port_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdat0,
    input  logic [DATA_W-1:0] wdat1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              RAMCS,
    output logic              RAMWE,
    output logic              RAMOE,
    output logic              RAMLB,
    output logic              RAMUB,
    output logic [ADDR_W-1:0] ADR,
    inout  wire  [DATA_W-1:0] DAT,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;  // 1: port 1 was granted last
    logic                port_q, port_d;              // port owning the current access
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   lat_adr_q, lat_adr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [1:0]          be_q, be_d;
    logic [3:0]          wait_q, wait_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cs_n_q, cs_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic [ADDR_W-1:0]   ram_adr_q, ram_adr_d;
    logic                dat_oe_q, dat_oe_d;
    logic                grant0, grant1;

    // Round-robin choice among live requests; only meaningful in IDLE.
    assign grant0 = (state_q == IDLE) && req0 && (!req1 || last_grant_q);
    assign grant1 = (state_q == IDLE) && req1 && (!req0 || !last_grant_q);

    // Next-state, field latching, handshake pulses and read-data capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        lat_adr_d    = lat_adr_q;
        wdat_d       = wdat_q;
        be_d         = be_q;
        wait_d       = wait_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata_d      = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    port_d = 1'b0; last_grant_d = 1'b0; ack0_d = 1'b1;
                    we_d = we0; lat_adr_d = adr0; wdat_d = wdat0; be_d = be0;
                    state_d = SETUP;
                end else if (grant1) begin
                    port_d = 1'b1; last_grant_d = 1'b1; ack1_d = 1'b1;
                    we_d = we1; lat_adr_d = adr1; wdat_d = wdat1; be_d = be1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                wait_d  = WAIT_LAST;
            end
            STROBE: begin
                if (wait_q == 4'd0) begin
                    state_d = HOLD;
                    if (!we_q) begin
                        // Deselected lanes read back as zero, not bus noise.
                        rdata_d   = {be_q[1] ? DAT[15:8] : 8'h00,
                                     be_q[0] ? DAT[7:0]  : 8'h00};
                        rvalid0_d = !port_q;
                        rvalid1_d = port_q;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin values for the coming cycle, derived from the next state so the
    // pins are registered yet line up with the state they belong to.
    always_comb begin
        cs_n_d    = 1'b1;
        we_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        ram_adr_d = ram_adr_q;
        dat_oe_d  = 1'b0;
        case (state_d)
            SETUP, STROBE: begin
                cs_n_d    = 1'b0;
                ram_adr_d = lat_adr_d;
                lb_n_d    = ~be_d[0];
                ub_n_d    = ~be_d[1];
                oe_n_d    = we_d;
                dat_oe_d  = we_d;
                we_n_d    = !((state_d == STROBE) && we_d);
            end
            HOLD: begin
                // Address, lanes and write data held one clock past the strobe.
                cs_n_d   = 1'b0;
                lb_n_d   = ~be_d[0];
                ub_n_d   = ~be_d[1];
                dat_oe_d = we_d;
            end
            default: ;
        endcase
    end

    // State register; reset releases the bus and strobes immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            lat_adr_q    <= '0;
            wdat_q       <= '0;
            be_q         <= 2'b00;
            wait_q       <= 4'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata_q      <= '0;
            cs_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            ram_adr_q    <= '0;
            dat_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            lat_adr_q    <= lat_adr_d;
            wdat_q       <= wdat_d;
            be_q         <= be_d;
            wait_q       <= wait_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata_q      <= rdata_d;
            cs_n_q       <= cs_n_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            lb_n_q       <= lb_n_d;
            ub_n_q       <= ub_n_d;
            ram_adr_q    <= ram_adr_d;
            dat_oe_q     <= dat_oe_d;
        end
    end

    assign DAT       = dat_oe_q ? wdat_q : {DATA_W{1'bz}};
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign RAMCS     = cs_n_q;
    assign RAMWE     = we_n_q;
    assign RAMOE     = oe_n_q;
    assign RAMLB     = lb_n_q;
    assign RAMUB     = ub_n_q;
    assign ADR       = ram_adr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scenario tasks against a WAIT_CYCLES=2 arbiter plus
// two small instances (WAIT_CYCLES=1 and 4) for the strobe-length sweep.
// The SRAM model drives ADR[15:0] onto the bus whenever CS and OE are low.
module tb_sram_port_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] adr0 = '0, adr1 = '0;
    logic [DW-1:0] wdat0 = '0, wdat1 = '0;
    logic [1:0]    be0 = 2'b00, be1 = 2'b00;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          RAMCS, RAMWE, RAMOE, RAMLB, RAMUB;
    logic [AW-1:0] ADR;
    wire  [DW-1:0] DAT;
    logic [1:0]    dbg_state;

    // Sweep instances: index 0 -> WAIT_CYCLES=1, index 1 -> WAIT_CYCLES=4.
    logic [1:0]          sw_req = 2'b00;
    logic [AW-1:0]       sw_adr_in = '0;
    wire  [1:0]          sw_ack0, sw_ack1, sw_rv0, sw_rv1;
    wire  [1:0]          sw_cs, sw_we, sw_oe, sw_lb, sw_ub;
    wire  [1:0][DW-1:0]  sw_rdata;
    wire  [1:0][AW-1:0]  sw_adr;
    wire  [1:0][1:0]     sw_st;
    wire  [DW-1:0]       sw_dat0, sw_dat1;

    logic [16:0]   exp_q[$];  // {port, expected rdata}
    int            tests = 0;
    int            fails = 0;

    logic [AW-1:0] wr_adr = '0;
    logic [DW-1:0] wr_dat = '0;

    int            obs_ack_at, obs_rv_at, obs_strobe, obs_we_low, obs_oe_low, obs_clash;
    int            obs_dat_hit, obs_lb_low, obs_ub_low, obs_cs_low, obs_other;
    logic [DW-1:0] obs_rd;

    // ---------------- clock / reset / SRAM models ----------------
    always #5 clk = ~clk;

    assign DAT     = (!RAMCS && !RAMOE) ? ADR[15:0] : 16'hzzzz;
    assign sw_dat0 = (!sw_cs[0] && !sw_oe[0]) ? sw_adr[0][15:0] : 16'hzzzz;
    assign sw_dat1 = (!sw_cs[1] && !sw_oe[1]) ? sw_adr[1][15:0] : 16'hzzzz;

    always @(posedge clk) begin
        if (rstn && !RAMCS && !RAMWE) begin
            wr_adr <= ADR;
            wr_dat <= DAT;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdat0(wdat0), .wdat1(wdat1),
        .be0(be0), .be1(be1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .RAMCS(RAMCS), .RAMWE(RAMWE), .RAMOE(RAMOE), .RAMLB(RAMLB), .RAMUB(RAMUB),
        .ADR(ADR), .DAT(DAT), .dbg_state(dbg_state)
    );

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rstn(rstn),
        .req0(sw_req[0]), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .adr0(sw_adr_in), .adr1(18'h0), .wdat0(16'h0), .wdat1(16'h0),
        .be0(2'b11), .be1(2'b00),
        .ack0(sw_ack0[0]), .ack1(sw_ack1[0]), .rvalid0(sw_rv0[0]), .rvalid1(sw_rv1[0]),
        .rdata(sw_rdata[0]),
        .RAMCS(sw_cs[0]), .RAMWE(sw_we[0]), .RAMOE(sw_oe[0]), .RAMLB(sw_lb[0]), .RAMUB(sw_ub[0]),
        .ADR(sw_adr[0]), .DAT(sw_dat0), .dbg_state(sw_st[0])
    );

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rstn(rstn),
        .req0(sw_req[1]), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .adr0(sw_adr_in), .adr1(18'h0), .wdat0(16'h0), .wdat1(16'h0),
        .be0(2'b11), .be1(2'b00),
        .ack0(sw_ack0[1]), .ack1(sw_ack1[1]), .rvalid0(sw_rv0[1]), .rvalid1(sw_rv1[1]),
        .rdata(sw_rdata[1]),
        .RAMCS(sw_cs[1]), .RAMWE(sw_we[1]), .RAMOE(sw_oe[1]), .RAMLB(sw_lb[1]), .RAMUB(sw_ub[1]),
        .ADR(sw_adr[1]), .DAT(sw_dat1), .dbg_state(sw_st[1])
    );

    // ---------------- driver ----------------
    // Issues one request on the main instance and records what the pins did,
    // cycle by cycle, until the access has returned to IDLE (bounded).
    task automatic run_access(input bit port, input bit we, input logic [AW-1:0] adr,
                              input logic [DW-1:0] wdat, input logic [1:0] be);
        obs_ack_at = -1; obs_rv_at = -1; obs_strobe = 0; obs_we_low = 0; obs_oe_low = 0;
        obs_clash = 0; obs_dat_hit = 0; obs_lb_low = 0; obs_ub_low = 0; obs_cs_low = 0;
        obs_other = 0; obs_rd = '0;
        @(negedge clk);
        if (port) begin req1 = 1'b1; we1 = we; adr1 = adr; wdat1 = wdat; be1 = be; end
        else      begin req0 = 1'b1; we0 = we; adr0 = adr; wdat0 = wdat; be0 = be; end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((port ? ack1 : ack0) && obs_ack_at < 0) begin
                obs_ack_at = k;
                if (port) req1 = 1'b0; else req0 = 1'b0;
            end
            if ((port ? ack0 : ack1) || (port ? rvalid0 : rvalid1)) obs_other++;
            if (dbg_state == 2'd2) obs_strobe++;
            if (!RAMWE) obs_we_low++;
            if (!RAMOE) obs_oe_low++;
            if (!RAMWE && !RAMOE) obs_clash++;
            if (!RAMCS) obs_cs_low++;
            if (!RAMCS && DAT === wdat) obs_dat_hit++;
            if (!RAMLB) obs_lb_low++;
            if (!RAMUB) obs_ub_low++;
            if ((port ? rvalid1 : rvalid0) && obs_rv_at < 0) begin obs_rv_at = k; obs_rd = rdata; end
            if (obs_ack_at > 0 && k > obs_ack_at && RAMCS) break;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({RAMCS, RAMWE, RAMOE, RAMLB, RAMUB} !== 5'b11111) begin fails++; $display("FAIL reset_strobes: got %b want 11111", {RAMCS, RAMWE, RAMOE, RAMLB, RAMUB}); end
        tests++; if (ADR !== 18'h0) begin fails++; $display("FAIL reset_adr: got %h want 0", ADR); end
        tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0000) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {ack0, ack1, rvalid0, rvalid1}); end
        tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if ({RAMCS, dbg_state} !== 3'b100) begin fails++; $display("FAIL reset_idle: got %b want 100", {RAMCS, dbg_state}); end
    endtask

    task automatic test_read();
        logic [16:0] e;
        exp_q.push_back({1'b0, 16'h1234});
        run_access(1'b0, 1'b0, 18'h01234, 16'h0000, 2'b11);
        e = exp_q.pop_front();
        tests++; if (obs_ack_at !== 1) begin fails++; $display("FAIL read_ack_cycle: got %0d want 1", obs_ack_at); end
        tests++; if (obs_rv_at !== 4) begin fails++; $display("FAIL read_rvalid_cycle: got %0d want 4", obs_rv_at); end
        tests++; if (obs_rd !== e[15:0]) begin fails++; $display("FAIL read_data: got %h want %h", obs_rd, e[15:0]); end
        tests++; if (obs_oe_low !== 3) begin fails++; $display("FAIL read_oe_cycles: got %0d want 3", obs_oe_low); end
        tests++; if (obs_we_low !== 0) begin fails++; $display("FAIL read_we_cycles: got %0d want 0", obs_we_low); end
        tests++; if (obs_strobe !== 2) begin fails++; $display("FAIL read_strobe_len: got %0d want 2", obs_strobe); end
        tests++; if (obs_other !== 0) begin fails++; $display("FAIL read_other_port: got %0d want 0", obs_other); end
    endtask

    task automatic test_write();
        run_access(1'b1, 1'b1, 18'h00010, 16'hBEEF, 2'b11);
        tests++; if (obs_ack_at !== 1) begin fails++; $display("FAIL write_ack_cycle: got %0d want 1", obs_ack_at); end
        tests++; if (obs_we_low !== 2) begin fails++; $display("FAIL write_we_cycles: got %0d want 2", obs_we_low); end
        tests++; if (obs_oe_low !== 0) begin fails++; $display("FAIL write_oe_cycles: got %0d want 0", obs_oe_low); end
        tests++; if (obs_dat_hit !== 4) begin fails++; $display("FAIL write_dat_cycles: got %0d want 4", obs_dat_hit); end
        tests++; if (obs_clash !== 0) begin fails++; $display("FAIL write_we_oe_clash: got %0d want 0", obs_clash); end
        tests++; if (obs_rv_at !== -1) begin fails++; $display("FAIL write_rvalid: got %0d want -1", obs_rv_at); end
        tests++; if ({wr_adr, wr_dat} !== {18'h00010, 16'hBEEF}) begin fails++; $display("FAIL write_sram_store: got %h/%h want 00010/beef", wr_adr, wr_dat); end
        tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL write_rdata_held: got %h want 1234", rdata); end
    endtask

    task automatic test_lanes();
        logic [16:0] e;
        exp_q.push_back({1'b0, 16'h005C});
        run_access(1'b0, 1'b0, 18'h00A5C, 16'h0000, 2'b01);
        e = exp_q.pop_front();
        tests++; if (obs_rd !== e[15:0]) begin fails++; $display("FAIL lanes_data: got %h want %h", obs_rd, e[15:0]); end
        tests++; if (!(obs_lb_low >= 3)) begin fails++; $display("FAIL lanes_lb_low: got %0d want >=3", obs_lb_low); end
        tests++; if (obs_ub_low !== 0) begin fails++; $display("FAIL lanes_ub_low: got %0d want 0", obs_ub_low); end
    endtask

    task automatic test_be_zero();
        logic [AW-1:0] a;
        logic [16:0]   e;
        a = 18'($urandom_range(0, 262143)) | 18'h00101;
        exp_q.push_back({1'b1, 16'h0000});
        run_access(1'b1, 1'b0, a, 16'h0000, 2'b00);
        e = exp_q.pop_front();
        tests++; if (obs_rv_at !== 4) begin fails++; $display("FAIL bezero_rvalid_cycle: got %0d want 4", obs_rv_at); end
        tests++; if (obs_rd !== e[15:0]) begin fails++; $display("FAIL bezero_data: got %h want %h", obs_rd, e[15:0]); end
        tests++; if ({obs_lb_low, obs_ub_low} !== {32'd0, 32'd0}) begin fails++; $display("FAIL bezero_lanes: got %0d/%0d want 0/0", obs_lb_low, obs_ub_low); end
        tests++; if (obs_cs_low !== 4) begin fails++; $display("FAIL bezero_cs_cycles: got %0d want 4", obs_cs_low); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0[2], a1[2];
        int            ack_port[4], ack_cyc[4];
        int            na, nr, n0, n1;
        logic [16:0]   e;
        for (int i = 0; i < 2; i++) begin
            a0[i] = 18'($urandom_range(0, 262143));
            a1[i] = 18'($urandom_range(0, 262143));
        end
        exp_q.push_back({1'b0, a0[0][15:0]});
        exp_q.push_back({1'b1, a1[0][15:0]});
        exp_q.push_back({1'b0, a0[1][15:0]});
        exp_q.push_back({1'b1, a1[1][15:0]});
        na = 0; nr = 0; n0 = 0; n1 = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; be0 = 2'b11; adr0 = a0[0];
        req1 = 1'b1; we1 = 1'b0; be1 = 2'b11; adr1 = a1[0];
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ack0) begin
                if (na < 4) begin ack_port[na] = 0; ack_cyc[na] = k; end
                na++; n0++;
                if (n0 < 2) adr0 = a0[n0]; else req0 = 1'b0;
            end
            if (ack1) begin
                if (na < 4) begin ack_port[na] = 1; ack_cyc[na] = k; end
                na++; n1++;
                if (n1 < 2) adr1 = a1[n1]; else req1 = 1'b0;
            end
            if (rvalid0 || rvalid1) begin
                nr++;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_unexpected_rvalid: got port %0d want none", rvalid1); end
                else begin
                    e = exp_q.pop_front();
                    if ({rvalid1, rdata} !== e) begin fails++; $display("FAIL b2b_rdata: got %0d/%h want %0d/%h", rvalid1, rdata, e[16], e[15:0]); end
                end
            end
            if (nr == 4) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        tests++; if (na !== 4 || nr !== 4) begin fails++; $display("FAIL b2b_counts: got %0d acks %0d rvalids want 4/4", na, nr); end
        if (na >= 4) begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (ack_port[i] !== (i % 2)) begin fails++; $display("FAIL b2b_order[%0d]: got port %0d want %0d", i, ack_port[i], i % 2); end
            end
            for (int i = 1; i < 4; i++) begin
                tests++; if (ack_cyc[i] - ack_cyc[i-1] !== 5) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, ack_cyc[i] - ack_cyc[i-1]); end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        int            quiet, first_port, nr;
        logic [16:0]   e;
        logic [AW-1:0] b0, b1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; adr0 = 18'h00040; wdat0 = 16'hBEEF; be0 = 2'b11;
        @(negedge clk);
        tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL rstmid_ack: got %b want 1", ack0); end
        req0 = 1'b0; we0 = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({dbg_state, RAMWE} !== 3'b100) begin fails++; $display("FAIL rstmid_in_strobe2: got %b want 100", {dbg_state, RAMWE}); end
        #1 rstn = 1'b0;
        #1;
        tests++; if ({RAMCS, RAMWE, RAMOE} !== 3'b111) begin fails++; $display("FAIL rstmid_strobes: got %b want 111", {RAMCS, RAMWE, RAMOE}); end
        tests++; if (DAT === 16'hBEEF) begin fails++; $display("FAIL rstmid_dat_release: got %h want released", DAT); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rstmid_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rstn = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1 || rvalid0 || rvalid1) quiet++;
        end
        tests++; if (quiet !== 0) begin fails++; $display("FAIL rstmid_dropped_op: got %0d pulses want 0", quiet); end
        b0 = 18'($urandom_range(0, 262143));
        b1 = 18'($urandom_range(0, 262143));
        exp_q.push_back({1'b0, b0[15:0]});
        exp_q.push_back({1'b1, b1[15:0]});
        req0 = 1'b1; adr0 = b0; be0 = 2'b11;
        req1 = 1'b1; adr1 = b1; be1 = 2'b11; we1 = 1'b0;
        first_port = -1; nr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack0) begin if (first_port < 0) first_port = 0; req0 = 1'b0; end
            if (ack1) begin if (first_port < 0) first_port = 1; req1 = 1'b0; end
            if (rvalid0 || rvalid1) begin
                nr++;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL rstmid_unexpected_rvalid: got port %0d want none", rvalid1); end
                else begin
                    e = exp_q.pop_front();
                    if ({rvalid1, rdata} !== e) begin fails++; $display("FAIL rstmid_rdata: got %0d/%h want %0d/%h", rvalid1, rdata, e[16], e[15:0]); end
                end
            end
            if (nr == 2) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        tests++; if (first_port !== 0) begin fails++; $display("FAIL rstmid_first_grant: got %0d want 0", first_port); end
        tests++; if (nr !== 2) begin fails++; $display("FAIL rstmid_rvalid_count: got %0d want 2", nr); end
        exp_q.delete();
    endtask

    task automatic test_sweep(input int k, input int wc);
        int            ack_at, rv_at, strobe;
        logic [AW-1:0] a;
        logic [16:0]   e;
        a = 18'($urandom_range(0, 262143));
        exp_q.push_back({1'b0, a[15:0]});
        ack_at = -1; rv_at = -1; strobe = 0;
        @(negedge clk);
        sw_adr_in = a; sw_req[k] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (sw_ack0[k] && ack_at < 0) begin ack_at = i; sw_req[k] = 1'b0; end
            if (sw_st[k] == 2'd2) strobe++;
            if (sw_rv0[k]) begin
                rv_at = i;
                e = exp_q.pop_front();
                tests++; if ({1'b0, sw_rdata[k]} !== e) begin fails++; $display("FAIL sweep_w%0d_data: got %h want %h", wc, sw_rdata[k], e[15:0]); end
                break;
            end
        end
        sw_req[k] = 1'b0;
        exp_q.delete();
        tests++; if (ack_at !== 1) begin fails++; $display("FAIL sweep_w%0d_ack: got %0d want 1", wc, ack_at); end
        tests++; if (strobe !== wc) begin fails++; $display("FAIL sweep_w%0d_strobe_len: got %0d want %0d", wc, strobe, wc); end
        tests++; if (rv_at !== wc + 2) begin fails++; $display("FAIL sweep_w%0d_rvalid_cycle: got %0d want %0d", wc, rv_at, wc + 2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_read();
        test_write();
        test_lanes();
        test_be_zero();
        test_back_to_back();
        test_reset_mid_write();
        test_sweep(0, 1);
        test_sweep(1, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
